// File: rtl/spm_ctrl.sv
// ---------------------------------------------------------------------------
// spm_ctrl -- sequencer for a serial-parallel multiplier (SPM).
//
// Accepts a signed multiplicand/multiplier pair. It holds the multiplicand on
// the SPM parallel input and streams the multiplier LSB first, sign-extended
// to 2W bits, into the SPM serial input. It collects the serial product
// stream into a 2W-bit signed product. Completion is signalled with a
// start / busy / done handshake.
//
// Optional feature macro: SPM_CTRL_ABORT_EN
//   When it is defined, the module gets an abort input. The abort cancels an
//   operation in CLR or RUN without a done pulse, and the product keeps its
//   old value.
//
// Ports
//   clk      in   1    system clock, rising edge
//   rst      in   1    asynchronous reset, active low
//   start    in   1    operation request, sampled only in IDLE
//   a        in   W    signed multiplicand, latched on accept
//   b        in   W    signed multiplier, latched on accept
//   abort    in   1    (SPM_CTRL_ABORT_EN only) cancel the current operation
//   spm_p    in   1    serial product bit from the SPM
//   busy     out  1    high in CLR, RUN and DONE
//   done     out  1    one-cycle pulse; product is valid from this cycle on
//   product  out  2W   signed a*b, held until the next done
//   spm_x    out  W    SPM parallel input, constant from one accept to the next
//   spm_y    out  1    SPM serial input
//   spm_clr  out  1    SPM synchronous clear
// ---------------------------------------------------------------------------
module spm_ctrl #(
    parameter int W     = 8,
    parameter int P_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
`ifdef SPM_CTRL_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  spm_p,
    output logic                  busy,
    output logic                  done,
    output logic signed [2*W-1:0] product,
    output logic signed [W-1:0]   spm_x,
    output logic                  spm_y,
    output logic                  spm_clr
);

    // The RUN counter spans 0 .. 2W+P_LAT-1.
    localparam int CW = $clog2(2*W + P_LAT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(2*W + P_LAT - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(2*W - 1);
    localparam logic [CW-1:0] CAP_FIRST  = CW'(P_LAT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CW-1:0]           cnt;
    logic signed [W-1:0]     bs;
    logic [2*W-1:0]          ps;
    logic [2*W-1:0]          ps_next;
    logic                    capture;
    logic                    abort_hit;

`ifdef SPM_CTRL_ABORT_EN
    assign abort_hit = abort && ((state_q == S_CLR) || (state_q == S_RUN));
`else
    assign abort_hit = 1'b0;
`endif

    // Product bits arrive LSB first. Each new bit enters at the top, so the
    // first bit ends up in bit 0 after 2W captures.
    assign capture = (state_q == S_RUN) && (cnt >= CAP_FIRST);
    assign ps_next = {spm_p, ps[2*W-1:1]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR:   state_d = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    // bs shifts right arithmetically during RUN. For the first W cycles,
    // bs[0] walks through b. After that it repeats the sign bit, which
    // produces the sign extension without any variable bit select.
    always_comb begin
        spm_y = 1'b0;
        if ((state_q == S_RUN) && (cnt <= DRIVE_LAST) && !abort_hit)
            spm_y = bs[0];
    end

    assign spm_clr = (state_q == S_CLR);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt     <= '0;
            bs      <= '0;
            ps      <= '0;
            product <= '0;
            spm_x   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        spm_x <= a;
                        bs    <= b;
                    end
                end
                S_CLR: begin
                    cnt <= '0;
                    ps  <= '0;
                end
                S_RUN: begin
                    cnt <= cnt + CNT_ONE;
                    bs  <= {bs[W-1], bs[W-1:1]};
                    if (capture) ps <= ps_next;
                    // The last capture and the product load share one edge.
                    if (state_d == S_DONE) product <= ps_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spm_ctrl -- bench for spm_ctrl (W=8, P_LAT=1) with a behavioural
// shift-add SPM model. When stimulus issues an operation, it queues the
// expected product and the expected done cycle. A monitor compares them
// whenever done is high.
// ---------------------------------------------------------------------------
module tb_spm_ctrl;

    localparam int W   = 8;
    localparam int LAT = 18;   // accept edge to done cycle, in edges

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
`ifdef SPM_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        spm_p;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  spm_x;
    logic        spm_y;
    logic        spm_clr;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    logic [15:0] exp_prod[$];
    int          exp_cyc[$];

    spm_ctrl #(.W(W), .P_LAT(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef SPM_CTRL_ABORT_EN
        .abort   (abort),
`endif
        .spm_p   (spm_p),
        .busy    (busy),
        .done    (done),
        .product (product),
        .spm_x   (spm_x),
        .spm_y   (spm_y),
        .spm_clr (spm_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPM model. Each edge adds x when y is 1, emits the LSB one edge later,
    // and keeps the arithmetically shifted remainder.
    int acc = 0;
    int xv;
    logic p_m = 1'b0;
    assign xv    = spm_y ? int'($signed(spm_x)) : 0;
    assign spm_p = p_m;
    always @(posedge clk) begin
        if (spm_clr) begin
            acc <= 0;
            p_m <= 1'b0;
        end else begin
            acc <= (acc + xv) >>> 1;
            p_m <= ((acc + xv) & 1) != 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (exp_prod.size() == 0) begin
                chk("unexpected_done", {16'h0, product}, 32'hDEAD_BEEF);
            end else begin
                chk("product", product, exp_prod.pop_front());
                chk("done_cycle", cyc, exp_cyc.pop_front());
                chk("busy_in_done", busy, 1);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] ex, input bit chk_busy);
        int n;
        bit ok;
        wait_idle();
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        start = 1'b0;
        exp_prod.push_back(ex);
        exp_cyc.push_back(n + LAT);
        chk("clr_phase", spm_clr, 1);
        chk("x_latched", spm_x, av);
        a = ~av;
        b = ~bv;
        if (chk_busy) begin
            ok = 1'b1;
            for (int i = 0; i < LAT; i++) begin
                @(negedge clk);
                if (busy !== 1'b1) ok = 1'b0;
            end
            chk("busy_throughout", ok, 1);
            chk("x_held", spm_x, av);
        end
    endtask

    logic [7:0]  pa [4] = '{8'h02, 8'hFB, 8'h02, 8'hFB};
    logic [7:0]  pb [4] = '{8'hFD, 8'h07, 8'hFD, 8'h07};
    logic [15:0] pe [4] = '{16'hFFFA, 16'hFFDD, 16'hFFFA, 16'hFFDD};

    initial begin
        int n0;
        int t;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_spm_x", spm_x, 0);
        chk("rst_spm_y", spm_y, 0);
        chk("rst_spm_clr", spm_clr, 0);
        rst = 1'b1;

        // Basic products
        do_op(8'h03, 8'h05, 16'h000F, 1'b1);
        do_op(8'hFF, 8'h01, 16'hFFFF, 1'b0);
        do_op(8'h80, 8'h80, 16'h4000, 1'b0);

        // A start pulse during RUN must be ignored
        do_op(8'h7F, 8'h80, 16'hC080, 1'b0);
        repeat (5) @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // start held high: accepts every 20 edges, so 19 non-done cycles
        // lie between consecutive done pulses
        wait_idle();
        a = pa[0];
        b = pb[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_prod.push_back(pe[k]);
            exp_cyc.push_back(n0 + 20 * k + LAT);
            if (k < 3) begin
                a = pa[k+1];
                b = pb[k+1];
                repeat (20) @(posedge clk);
                #1;
            end
        end
        start = 1'b0;

        // Reset at RUN cnt=7
        wait_idle();
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_product", product, 0);
        chk("mid_rst_spm_x", spm_x, 0);
        chk("mid_rst_spm_y", spm_y, 0);
        chk("mid_rst_spm_clr", spm_clr, 0);
        @(negedge clk);
        rst = 1'b1;
        do_op(8'h02, 8'h03, 16'h0006, 1'b0);

`ifdef SPM_CTRL_ABORT_EN
        // Abort at cnt=4 during 9*9
        wait_idle();
        a = 8'h09;
        b = 8'h09;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_spm_y", spm_y, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        repeat (25) @(negedge clk);
        chk("abort_product_kept", product, 16'h0006);
        do_op(8'h09, 8'h09, 16'h0051, 1'b0);
`endif

        // Drain the scoreboard, then watch a little longer for stray pulses
        t = 0;
        while (exp_prod.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_prod.size(), 0);
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
